// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - round-robin sharing of one sync-read instruction memory among NUM_PE fetchers
module imem_fetch_arbiter #(
  parameter int NUM_PE = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PE-1:0]        req,
  input  logic [NUM_PE*32-1:0]     req_pc,
  output logic [NUM_PE-1:0]        req_ready,
  input  logic [NUM_PE-1:0]        flush,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [NUM_PE-1:0]        resp_valid,
  output logic [NUM_PE*DATA_W-1:0] resp_instr,
  output logic                     busy
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [NUM_PE-1:0]        pending_q, pending_d;
  logic [ADDR_W-1:0]        pc_q [NUM_PE];
  logic [ADDR_W-1:0]        pc_d [NUM_PE];
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     infl_v_q, infl_v_d;
  logic [PTR_W-1:0]         infl_id_q, infl_id_d;
  logic [NUM_PE-1:0]        resp_valid_q, resp_valid_d;
  logic [NUM_PE*DATA_W-1:0] resp_instr_q, resp_instr_d;

  logic [NUM_PE-1:0] cand;
  logic              win_v;
  logic [PTR_W-1:0]  win_id;
  logic [PTR_W:0]    scan_sum;
  logic [PTR_W-1:0]  scan_idx;
  logic              unused_pc_bits;

  // Only the word-index bits of each PC reach the memory; the rest wrap silently.
  assign unused_pc_bits = ^req_pc;

  always_comb begin
    cand     = pending_q & ~flush;
    win_v    = 1'b0;
    win_id   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_PE)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_PE);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!win_v && cand[scan_idx]) begin
        win_v  = 1'b1;
        win_id = scan_idx;
      end
    end
  end

  assign mem_en     = win_v;
  assign mem_addr   = pc_q[win_id];
  assign req_ready  = ~pending_q;
  assign busy       = (|pending_q) | infl_v_q;
  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;

  always_comb begin
    pending_d    = pending_q;
    pc_d         = pc_q;
    rr_ptr_d     = rr_ptr_q;
    infl_v_d     = win_v;
    infl_id_d    = infl_id_q;
    resp_valid_d = '0;
    resp_instr_d = resp_instr_q;

    if (win_v) begin
      pending_d[win_id] = 1'b0;
      infl_id_d         = win_id;
      rr_ptr_d          = (win_id == PTR_W'(NUM_PE-1)) ? '0 : win_id + PTR_W'(1);
    end

    // A granted slot is still pending this cycle, so it cannot re-accept until next cycle.
    for (int i = 0; i < NUM_PE; i++) begin
      if (flush[i]) begin
        pending_d[i] = 1'b0;
      end else if (req[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        pc_d[i]      = req_pc[32*i +: ADDR_W];
      end

      if (infl_v_q && (infl_id_q == PTR_W'(i)) && !flush[i]) begin
        resp_valid_d[i]                   = 1'b1;
        resp_instr_d[DATA_W*i +: DATA_W]  = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      infl_v_q     <= 1'b0;
      infl_id_q    <= '0;
      resp_valid_q <= '0;
      resp_instr_q <= '0;
      for (int i = 0; i < NUM_PE; i++) begin
        pc_q[i] <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      infl_v_q     <= infl_v_d;
      infl_id_q    <= infl_id_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      for (int i = 0; i < NUM_PE; i++) begin
        pc_q[i] <= pc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - directed bench with response scoreboard for imem_fetch_arbiter
module tb_imem_fetch_arbiter;

  localparam int NUM_PE = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_PE-1:0]        req;
  logic [NUM_PE*32-1:0]     req_pc;
  logic [NUM_PE-1:0]        req_ready;
  logic [NUM_PE-1:0]        flush;
  logic                     mem_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_rdata;
  logic [NUM_PE-1:0]        resp_valid;
  logic [NUM_PE*DATA_W-1:0] resp_instr;
  logic                     busy;

  imem_fetch_arbiter #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_pc     (req_pc),
    .req_ready  (req_ready),
    .flush      (flush),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_instr (resp_instr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int          pe;
    logic [31:0] instr;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_instr [NUM_PE];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_resp();
    exp_t         e;
    logic [127:0] model;
    logic [3:0]   onehot;
    chk("resp_onehot0", 128'($onehot0(resp_valid)), 128'd1);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e      = sb.pop_front();
      onehot = 4'(1 << e.pe);
      chk("resp_valid", 128'(resp_valid), 128'(onehot));
      exp_instr[e.pe] = e.instr;
      for (int i = 0; i < NUM_PE; i++) model[32*i +: 32] = exp_instr[i];
      chk("resp_instr", resp_instr, model);
    end else begin
      chk("resp_idle", 128'(resp_valid), 128'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    check_resp();
  endtask

  task automatic set_pc(input int pe, input logic [31:0] pc);
    req_pc[32*pe +: 32] = pc;
  endtask

  task automatic push(input int pe, input int addr, input int dcyc);
    sb.push_back('{pe, mem[addr], cyc + dcyc});
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_PE; i++) exp_instr[i] = 32'h0;
  endtask

  logic [7:0] rr_addr [5];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i * 32'h0101;
    mem[8'h10] = 32'h0050_0093;
    rr_addr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40};
    clear_model();
    rst = 1'b1; req = '0; req_pc = '0; flush = '0;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    chk("rst_mem_en", 128'(mem_en), 128'd0);
    chk("rst_req_ready", 128'(req_ready), 128'hF);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_resp_instr", resp_instr, 128'd0);
    step();

    // Single fetch from PE2
    req = 4'b0100; set_pc(2, 32'h10);
    step();
    req = '0;
    chk("single_mem_en", 128'(mem_en), 128'd1);
    chk("single_mem_addr", 128'(mem_addr), 128'h10);
    chk("single_req_ready", 128'(req_ready), 128'b1011);
    chk("single_busy", 128'(busy), 128'd1);
    push(2, 8'h10, 2);
    step();
    chk("single_mem_idle", 128'(mem_en), 128'd0);
    step(); step();
    chk("single_busy_done", 128'(busy), 128'd0);

    // Round-robin from rr_ptr=0, PE0 re-requests immediately
    rst = 1'b1; step(); rst = 1'b0; clear_model();
    req = 4'b1111;
    for (int i = 0; i < NUM_PE; i++) set_pc(i, i);
    step();
    set_pc(0, 32'h40);
    push(0, 8'h00, 2); push(1, 8'h01, 3); push(2, 8'h02, 4); push(3, 8'h03, 5); push(0, 8'h40, 6);
    for (int k = 0; k < 5; k++) begin
      chk("rr_mem_en", 128'(mem_en), 128'd1);
      chk("rr_mem_addr", 128'(mem_addr), 128'(rr_addr[k]));
      if (k == 2) req = '0;
      step();
    end
    step();
    chk("rr_busy_done", 128'(busy), 128'd0);

    // Back-pressure: PC change while pending is ignored
    req = 4'b0010; set_pc(1, 32'h20);
    step();
    set_pc(1, 32'h30);
    chk("bp_req_ready", 128'(req_ready), 128'b1101);
    chk("bp_mem_addr0", 128'(mem_addr), 128'h20);
    push(1, 8'h20, 2);
    step();
    chk("bp_ready_back", 128'(req_ready), 128'hF);
    chk("bp_no_grant", 128'(mem_en), 128'd0);
    step();
    chk("bp_mem_en1", 128'(mem_en), 128'd1);
    chk("bp_mem_addr1", 128'(mem_addr), 128'h30);
    push(1, 8'h30, 2);
    req = '0;
    step(); step(); step();

    // Flush of an in-flight fetch
    req = 4'b1000; set_pc(3, 32'h50);
    step();
    req = '0;
    chk("fl_mem_addr", 128'(mem_addr), 128'h50);
    step();
    flush = 4'b1000;
    step();
    flush = '0;
    chk("fl_instr3_kept", 128'(resp_instr[127:96]), 128'(exp_instr[3]));
    chk("fl_busy", 128'(busy), 128'd0);

    // Flush of a pending-only slot, and flush blocking an accept
    req = 4'b0110; set_pc(1, 32'h61); set_pc(2, 32'h62);
    step();
    chk("flp_mem_addr", 128'(mem_addr), 128'h61);
    push(1, 8'h61, 2);
    req = 4'b0001; set_pc(0, 32'h70); flush = 4'b0101;
    step();
    req = '0; flush = '0;
    chk("flp_no_grant", 128'(mem_en), 128'd0);
    chk("flp_req_ready", 128'(req_ready), 128'hF);
    step(); step();
    chk("flp_busy", 128'(busy), 128'd0);

    // PC wrap to the word index
    req = 4'b0001; set_pc(0, 32'h0000_0105);
    step();
    req = '0;
    chk("wrap_mem_addr", 128'(mem_addr), 128'h05);
    push(0, 8'h05, 2);
    step(); step();

    // Reset in the cycle after a grant
    req = 4'b0100; set_pc(2, 32'h07);
    step();
    req = '0;
    chk("rmid_mem_en", 128'(mem_en), 128'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; clear_model();
    chk("rmid_busy", 128'(busy), 128'd0);
    chk("rmid_resp_instr", resp_instr, 128'd0);
    step();
    chk("rmid_busy2", 128'(busy), 128'd0);

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
